// File: rtl/parity_stream_gen_chk_if.sv
// Stream bus for parity_stream_gen_chk: input word side (s_*) and registered output side (m_*).
// Parity width follows PARITY_BYTE_EN: one bit per byte lane when defined, one bit otherwise.
interface parity_stream_gen_chk_if #(
    parameter int DATA_W = 32
);
`ifdef PARITY_BYTE_EN
    localparam int PW = DATA_W / 8;
`else
    localparam int PW = 1;
`endif

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [PW-1:0]     s_par;
    logic              s_chk;
    logic              odd_sel;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [PW-1:0]     m_par;
    logic              m_err;

    // Source/sink side that feeds words in and drains them out.
    modport master (
        output s_valid, s_data, s_par, s_chk, odd_sel, m_ready,
        input  s_ready, m_valid, m_data, m_par, m_err
    );

    // Parity engine side.
    modport slave (
        input  s_valid, s_data, s_par, s_chk, odd_sel, m_ready,
        output s_ready, m_valid, m_data, m_par, m_err
    );
endinterface

// File: rtl/parity_stream_gen_chk.sv
// Streaming parity generator/checker with one registered output stage and a saturating error counter.
// Optional feature macro PARITY_BYTE_EN: per-byte-lane parity instead of one bit over the whole word.
module parity_stream_gen_chk #(
    parameter int DATA_W    = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    parity_stream_gen_chk_if.slave bus,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);
`ifdef PARITY_BYTE_EN
    localparam int PW = DATA_W / 8;
    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("parity_stream_gen_chk: DATA_W must be a multiple of 8 with PARITY_BYTE_EN");
    end
`else
    localparam int PW = 1;
`endif

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    logic              m_valid_q;
    logic [DATA_W-1:0] m_data_q;
    logic [PW-1:0]     m_par_q;
    logic              m_err_q;
    logic [PW-1:0]     par_calc;
    logic              accept;
    logic              mismatch;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        par_calc = '0;
`ifdef PARITY_BYTE_EN
        for (int i = 0; i < PW; i++) begin
            par_calc[i] = (^bus.s_data[8*i +: 8]) ^ bus.odd_sel;
        end
`else
        par_calc[0] = (^bus.s_data) ^ bus.odd_sel;
`endif
    end

    // A vector compare is the OR over lanes of per-lane mismatches.
    assign mismatch    = bus.s_chk && (bus.s_par != par_calc);
    assign bus.s_ready = !m_valid_q || bus.m_ready;
    assign accept      = bus.s_valid && bus.s_ready;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    // NOTE: only control/data registers here are reset; there is no memory array to clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_par_q   <= '0;
            m_err_q   <= 1'b0;
        end else if (accept) begin
            m_valid_q <= 1'b1;
            m_data_q  <= bus.s_data;
            m_par_q   <= par_calc;
            m_err_q   <= mismatch;
        end else if (bus.m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= (accept && mismatch) ? ERR_CNT_W'(1) : '0;
        end else if (accept && mismatch && err_cnt != CNT_MAX) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_par   = m_par_q;
    assign bus.m_err   = m_err_q;
endmodule
